// File: rtl/rrp_add_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rrp_pkg: shared definitions for the rRp_add arbiter slice.
//   digit_bits   : bits per signed digit for a given radix
//   operand_bits : bits per WIDTH-digit operand
//   id_bits      : requester index width (at least 1)
//   digit_at     : extract and sign-extend one digit from a packed vector
//   state_t      : output-stage FSM state
// ---------------------------------------------------------------------------
package rrp_pkg;

   // Widest packed vector digit_at accepts; callers zero-extend to this.
   localparam int MAX_VEC = 256;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   function automatic int digit_bits(input int radix);
      return $clog2(radix) + 1;
   endfunction

   function automatic int operand_bits(input int radix, input int width);
      return digit_bits(radix) * width;
   endfunction

   function automatic int id_bits(input int nreq);
      return (nreq > 2) ? $clog2(nreq) : 1;
   endfunction

   // Digit idx of a vector packed d bits per digit, two's complement.
   function automatic int digit_at(input logic [MAX_VEC-1:0] vec, input int idx, input int d);
      logic [MAX_VEC-1:0] sh;
      int                 raw;
      sh  = vec >> (idx * d);
      raw = int'(sh[31:0] & ((32'd1 << d) - 32'd1));
      if (raw >= (1 << (d - 1))) raw -= (1 << d);
      return raw;
   endfunction

endpackage

// File: rtl/rrp_add_arbiter_if.sv
// ---------------------------------------------------------------------------
// rrp_add_arbiter_if: request and result handshake bundle.
//   req_valid/req_ready : per-requester valid, one-hot grant
//   req_x/req_y         : NREQ packed operands, requester k at [k*N +: N]
//   out_valid/out_ready : single-entry result handshake
//   out_s/out_id        : WIDTH+1 digit sum and producing requester
// master = requesters + downstream sink, slave = the arbiter.
// ---------------------------------------------------------------------------
interface rrp_add_arbiter_if #(
   parameter int RADIX = 2,
   parameter int WIDTH = 6,
   parameter int NREQ  = 4
);
   import rrp_pkg::*;

   localparam int D   = digit_bits(RADIX);
   localparam int N   = operand_bits(RADIX, WIDTH);
   localparam int IDW = id_bits(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_x;
   logic [NREQ*N-1:0] req_y;
   logic              out_valid;
   logic              out_ready;
   logic [N+D-1:0]    out_s;
   logic [IDW-1:0]    out_id;

   modport master (
      output req_valid, req_x, req_y, out_ready,
      input  req_ready, out_valid, out_s, out_id
   );

   modport slave (
      input  req_valid, req_x, req_y, out_ready,
      output req_ready, out_valid, out_s, out_id
   );

endinterface

// File: rtl/rrp_add.sv
// ---------------------------------------------------------------------------
// rrp_add: combinational signed-digit adder.
//   x_i, y_i : WIDTH digits, D bits each, two's complement, |digit| < RADIX
//   s_o      : WIDTH+1 digits, value(s_o) = value(x_i) + value(y_i)
// Each position folds its digit sum into range with a transfer of -1/0/+1
// into the next position; the final transfer becomes the top digit.
// ---------------------------------------------------------------------------
module rrp_add
   import rrp_pkg::*;
#(
   parameter int RADIX = 2,
   parameter int WIDTH = 6,
   localparam int D    = digit_bits(RADIX),
   localparam int N    = D * WIDTH
) (
   input  logic [N-1:0]   x_i,
   input  logic [N-1:0]   y_i,
   output logic [N+D-1:0] s_o
);

   int carry;
   int dsum;
   int dig;

   // NOTE: combinational logic uses blocking assignments and gives every
   // output a default first, so no path can leave a latch behind.
   always_comb begin
      s_o   = '0;
      carry = 0;
      dsum  = 0;
      dig   = 0;
      for (int i = 0; i < WIDTH; i++) begin
         dsum = digit_at(MAX_VEC'(x_i), i, D) + digit_at(MAX_VEC'(y_i), i, D) + carry;
         if (dsum > RADIX - 1) begin
            carry = 1;
            dig   = dsum - RADIX;
         end else if (dsum < -(RADIX - 1)) begin
            carry = -1;
            dig   = dsum + RADIX;
         end else begin
            carry = 0;
            dig   = dsum;
         end
         s_o[i*D +: D] = dig[D-1:0];
      end
      s_o[WIDTH*D +: D] = carry[D-1:0];
   end

endmodule

// File: rtl/rrp_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rrp_rr_arbiter: combinational round-robin priority select.
//   req_i    : request vector
//   ptr_i    : highest-priority index this cycle
//   win_o    : one-hot winner (zero when no request)
//   win_id_o : encoded winner (0 when no request)
// Wrap uses an explicit compare so non-power-of-two NREQ works.
// ---------------------------------------------------------------------------
module rrp_rr_arbiter
   import rrp_pkg::*;
#(
   parameter int NREQ  = 4,
   localparam int IDW  = id_bits(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] win_o,
   output logic [IDW-1:0]  win_id_o
);

   int             idx;
   logic [IDW-1:0] sel;
   logic           found;

   always_comb begin
      win_o    = '0;
      win_id_o = '0;
      found    = 1'b0;
      idx      = 0;
      sel      = '0;
      for (int off = 0; off < NREQ; off++) begin
         idx = int'(ptr_i) + off;
         if (idx >= NREQ) idx -= NREQ;
         sel = IDW'(idx);
         if (!found && req_i[sel]) begin
            found      = 1'b1;
            win_o[sel] = 1'b1;
            win_id_o   = sel;
         end
      end
   end

endmodule

// File: rtl/rrp_add_arbiter.sv
// ---------------------------------------------------------------------------
// rrp_add_arbiter: NREQ requesters share one rrp_add through a round-robin
// arbiter; the sum lands in a single-entry output register tagged with the
// requester index.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rrp_add_arbiter_if.slave (request and result handshakes)
// A new pair is accepted when the output register is empty or being popped
// this cycle, so pop and push can share an edge.
// ---------------------------------------------------------------------------
module rrp_add_arbiter
   import rrp_pkg::*;
#(
   parameter int RADIX = 2,
   parameter int WIDTH = 6,
   parameter int NREQ  = 4
) (
   input logic             clk,
   input logic             rst_n,
   rrp_add_arbiter_if.slave bus
);

   localparam int D   = digit_bits(RADIX);
   localparam int N   = operand_bits(RADIX, WIDTH);
   localparam int IDW = id_bits(NREQ);
   localparam int SW  = N + D;

   logic [NREQ-1:0] win;
   logic [IDW-1:0]  win_id;
   logic            can_accept;
   logic            accept;
   logic [N-1:0]    x_sel;
   logic [N-1:0]    y_sel;
   logic [SW-1:0]   sum;

   state_t          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [SW-1:0]   s_q, s_d;
   logic [IDW-1:0]  id_q, id_d;

   rrp_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req_i    (bus.req_valid),
      .ptr_i    (ptr_q),
      .win_o    (win),
      .win_id_o (win_id)
   );

   assign can_accept = (state_q == EMPTY) | bus.out_ready;
   // Gate with rst_n: during reset the FSM reads EMPTY, which would
   // otherwise let a grant through.
   assign bus.req_ready = rst_n ? (win & {NREQ{can_accept}}) : '0;
   assign accept        = |bus.req_ready;

   assign x_sel = bus.req_x[int'(win_id)*N +: N];
   assign y_sel = bus.req_y[int'(win_id)*N +: N];

   rrp_add #(.RADIX(RADIX), .WIDTH(WIDTH)) u_add (
      .x_i (x_sel),
      .y_i (y_sel),
      .s_o (sum)
   );

   // FSM: state register
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (accept) state_d = FULL;
         FULL:  if (!accept && bus.out_ready) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // FSM: outputs
   always_comb begin
      bus.out_valid = (state_q == FULL);
   end

   // Datapath next values: capture on accept, otherwise hold.
   always_comb begin
      ptr_d = ptr_q;
      s_d   = s_q;
      id_d  = id_q;
      if (accept) begin
         ptr_d = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
         s_d   = sum;
         id_d  = win_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         s_q   <= '0;
         id_q  <= '0;
      end else begin
         ptr_q <= ptr_d;
         s_q   <= s_d;
         id_q  <= id_d;
      end
   end

   assign bus.out_s  = s_q;
   assign bus.out_id = id_q;

endmodule

// File: tb/tb_rrp_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rrp_add_arbiter: directed checks for RADIX=2, WIDTH=6, NREQ=4 followed
// by a randomised run against a small reference model.
// ---------------------------------------------------------------------------
module tb_rrp_add_arbiter;

   localparam logic [11:0] ALL_P = 12'b01_01_01_01_01_01;
   localparam logic [11:0] ALL_N = 12'b11_11_11_11_11_11;
   localparam logic [11:0] ZERO  = 12'd0;

   logic clk = 1'b0;
   logic rst_n;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state for the random phase
   int m_ptr;
   int m_full;
   int m_id;
   int m_val;
   int gk;
   int idx;

   rrp_add_arbiter_if #(.RADIX(2), .WIDTH(6), .NREQ(4)) bus ();

   rrp_add_arbiter #(.RADIX(2), .WIDTH(6), .NREQ(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Value of a packed 2-bit signed-digit vector (7 digits, LSD first).
   function automatic int dec(input logic [13:0] s);
      int               v;
      logic signed [1:0] d;
      v = 0;
      for (int i = 0; i < 7; i++) begin
         d = s[2*i +: 2];
         v += int'(d) * (2 ** i);
      end
      return v;
   endfunction

   function automatic logic [11:0] rnd_operand();
      logic [11:0] r;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         case ($urandom_range(0, 2))
            0:       r[2*i +: 2] = 2'b11;
            1:       r[2*i +: 2] = 2'b00;
            default: r[2*i +: 2] = 2'b01;
         endcase
      end
      return r;
   endfunction

   task automatic set_pair(input int k, input logic [11:0] x, input logic [11:0] y);
      bus.req_x[k*12 +: 12] = x;
      bus.req_y[k*12 +: 12] = y;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = 4'hF;
      bus.req_x     = '0;
      bus.req_y     = '0;
      bus.out_ready = 1'b0;

      // Reset state, with requests present to prove grants are gated
      repeat (2) tick();
      check("rst_ready", bus.req_ready, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_s",     bus.out_s,     0);
      check("rst_id",    bus.out_id,    0);

      bus.req_valid = 4'h0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_valid", bus.out_valid, 0);
         check("idle_ready", bus.req_ready, 0);
         check("idle_s",     bus.out_s,     0);
      end

      // Single requester, all +1 digits, then all -1 digits
      set_pair(1, ALL_P, ALL_P);
      bus.req_valid = 4'b0010;
      bus.out_ready = 1'b1;
      #1 check("p1_ready", bus.req_ready, 4'b0010);
      tick();
      bus.req_valid = 4'b0000;
      #1;
      check("p1_valid", bus.out_valid, 1);
      check("p1_id",    bus.out_id,    1);
      check("p1_sum",   dec(bus.out_s), 126);
      check("p1_ready_after", bus.req_ready, 0);

      set_pair(1, ALL_N, ALL_N);
      bus.req_valid = 4'b0010;
      #1 check("n1_ready", bus.req_ready, 4'b0010);
      tick();
      bus.req_valid = 4'b0000;
      #1;
      check("n1_valid", bus.out_valid, 1);
      check("n1_id",    bus.out_id,    1);
      check("n1_sum",   dec(bus.out_s), -126);
      tick();
      check("n1_pop", bus.out_valid, 0);

      // Fresh reset, then all four valid: grants 0,1,2,3,0,1
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      for (int k = 0; k < 4; k++) set_pair(k, ALL_P, ZERO);
      bus.req_valid = 4'hF;
      for (int i = 0; i < 6; i++) begin
         #1 check("rr_grant", bus.req_ready, 1 << (i % 4));
         tick();
         check("rr_valid", bus.out_valid, 1);
         check("rr_id",    bus.out_id,    i % 4);
      end

      // Grant 2, then requesters 1 and 3: 3 first, then 1
      bus.req_valid = 4'b0100;
      #1 check("g2_ready", bus.req_ready, 4'b0100);
      tick();
      check("g2_id", bus.out_id, 2);
      bus.req_valid = 4'b1010;
      #1 check("g3_ready", bus.req_ready, 4'b1000);
      tick();
      check("g3_id", bus.out_id, 3);
      bus.req_valid = 4'b0010;
      #1 check("g1_ready", bus.req_ready, 4'b0010);
      tick();
      check("g1_id",  bus.out_id, 1);
      check("g1_sum", dec(bus.out_s), 63);

      // Backpressure: result held, no grants, ptr frozen at 2
      bus.out_ready = 1'b0;
      bus.req_valid = 4'hF;
      for (int k = 0; k < 4; k++) set_pair(k, ALL_N, ZERO);
      for (int i = 0; i < 4; i++) begin
         #1 check("bp_ready", bus.req_ready, 0);
         tick();
         check("bp_valid", bus.out_valid, 1);
         check("bp_id",    bus.out_id,    1);
         check("bp_sum",   dec(bus.out_s), 63);
      end
      bus.out_ready = 1'b1;
      #1 check("bp_rel_ready", bus.req_ready, 4'b0100);
      tick();
      bus.req_valid = 4'h0;
      #1;
      check("bp_rel_valid", bus.out_valid, 1);
      check("bp_rel_id",    bus.out_id,    2);
      check("bp_rel_sum",   dec(bus.out_s), -63);
      tick();
      check("bp_drain", bus.out_valid, 0);

      // Random phase from a known reset state
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      m_ptr  = 0;
      m_full = 0;
      m_id   = 0;
      m_val  = 0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         @(negedge clk);
         gk = -1;
         if (m_full == 0 || bus.out_ready) begin
            for (int off = 0; off < 4; off++) begin
               idx = (m_ptr + off) % 4;
               if (gk < 0 && bus.req_valid[idx]) gk = idx;
            end
         end
         check("rnd_ready", bus.req_ready, (gk >= 0) ? (1 << gk) : 0);
         check("rnd_valid", bus.out_valid, m_full);
         if (m_full != 0) begin
            check("rnd_id",  bus.out_id,     m_id);
            check("rnd_sum", dec(bus.out_s), m_val);
         end
         if (gk >= 0) begin
            m_full = 1;
            m_id   = gk;
            m_val  = dec({2'b00, bus.req_x[gk*12 +: 12]}) + dec({2'b00, bus.req_y[gk*12 +: 12]});
            m_ptr  = (gk + 1) % 4;
         end else if (bus.out_ready) begin
            m_full = 0;
         end
         tick();
         for (int k = 0; k < 4; k++) begin
            if (k == gk) begin
               bus.req_valid[k] = ($urandom_range(0, 1) == 1);
               set_pair(k, rnd_operand(), rnd_operand());
            end else if (!bus.req_valid[k]) begin
               if ($urandom_range(0, 2) == 0) begin
                  set_pair(k, rnd_operand(), rnd_operand());
                  bus.req_valid[k] = 1'b1;
               end
            end else if ($urandom_range(0, 9) == 0) begin
               bus.req_valid[k] = 1'b0;
            end
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
      end

      // Reset while FULL: out_valid drops without a clock edge
      bus.out_ready = 1'b0;
      bus.req_valid = 4'hF;
      tick();
      tick();
      check("pre_rst_valid", bus.out_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      check("async_valid", bus.out_valid, 0);
      check("async_ready", bus.req_ready, 0);
      check("async_s",     bus.out_s,     0);
      check("async_id",    bus.out_id,    0);
      tick();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      #1 check("post_rst_ready", bus.req_ready, 4'b0001);
      tick();
      check("post_rst_valid", bus.out_valid, 1);
      check("post_rst_id",    bus.out_id,    0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rrp_add_arbiter.md
Name: rrp_add_arbiter

Overview:
- Shares one combinational rRp_add redundant signed-digit adder between NREQ requesters.
- Each requester presents an operand pair (x, y) with a valid/ready handshake.
- A round-robin arbiter selects one requester per cycle and drives the adder with its pair.
- The sum is registered into a single-entry output stage, tagged with the requester ID, and offered downstream with valid/ready backpressure.

Parameters:
- RADIX, 2: digit radix; digit range is [-(RADIX-1), RADIX-1].
- WIDTH, 6: digits per operand.
- NREQ, 4: number of requesters (2..16).
- Local D = $clog2(RADIX)+1: bits per digit.
- Local N = D*WIDTH: operand width.
- Local IDW = max(1, $clog2(NREQ)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  bit k: requester k presents a pair.
- req_ready  out  NREQ  one-hot (or zero) grant/accept.
- req_x  in  NREQ*N  requester k's x at [k*N +: N]; digit i at [i*D +: D], two's complement.
- req_y  in  NREQ*N  same layout as req_x.
- out_valid  out  1  result register holds a sum.
- out_ready  in  1  downstream accepts the result.
- out_s  out  N+D  WIDTH+1 digit sum, same digit encoding.
- out_id  out  IDW  index of the requester that produced out_s.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_s=0, out_id=0, rr pointer ptr=0, FSM=EMPTY. While rst_n=0, req_ready=0.
- FSM has two states, EMPTY and FULL; out_valid = (state==FULL).
- can_accept = (state==EMPTY) | out_ready.
- Arbitration is combinational:
  - Scan requesters starting at ptr, incrementing mod NREQ; the first k with req_valid[k]=1 wins.
  - req_ready[k] = win[k] & can_accept. At most one bit of req_ready is set.
  - req_ready never depends on out_ready when state==EMPTY.
- Handshake: a transfer occurs on a cycle with req_valid[k] & req_ready[k]. On that edge:
  - out_s <= rRp_add(req_x[k], req_y[k]);
  - out_id <= k;
  - state <= FULL;
  - ptr <= (k+1) mod NREQ.
- Latency: 1 cycle from accept to out_valid. Throughput is 1 result per cycle when out_ready is held at 1.
- Output handshake:
  - FULL & out_ready & no new accept -> EMPTY.
  - FULL & out_ready & new accept -> remain FULL with the new data (simultaneous pop and push).
  - FULL & !out_ready -> out_s and out_id held bit-stable; req_ready=0; ptr unchanged.
- No requester valid: ptr unchanged and state follows the output handshake only.
- Requesters hold x and y stable while valid and not ready. Withdrawing valid before the grant is permitted; the arbiter simply re-scans.
- Arithmetic:
  - Performed entirely by the rRp_add instance, which is combinational and takes WIDTH-digit inputs.
  - Output is WIDTH+1 digits with value(out_s) = value(x) + value(y) exactly, where value = sum over i of digit_i*RADIX^i.
  - No saturation and no range check.
- NREQ not a power of two: the ptr wrap uses an explicit compare to NREQ-1, not bit truncation.
- Reset mid-operation discards the held result. Requesters must re-present any pair whose transfer had not completed.

Decomposition:
- Shared package rrp_pkg holds:
  - the D and N derivation functions;
  - the digit-extract helper;
  - the IDW function;
  - FSM state typedef {EMPTY, FULL}.
- Sub-module rrp_rr_arbiter: NREQ-wide round-robin priority select. Inputs req and ptr; outputs one-hot win and encoded win_id.
- Top level contains:
  - operand mux;
  - rRp_add instance;
  - output register;
  - FSM;
  - ptr register.
- Estimated size ~200 lines total.

Test Plan (RADIX=2, WIDTH=6, NREQ=4):
- Reset release, no requests -> out_valid=0, req_ready=0000, out_s=0 for 5 cycles.
- Req 1 only, x=all digits +1 (63), y=all +1 (63), out_ready=1 -> req_ready=0010 for one cycle; next cycle out_valid=1, out_id=1, decoded out_s=126. Repeat with all digits -1 -> out_s=-126.
- All four valid continuously, out_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles; out_id follows one cycle later.
- After grant to 2, req 1 and req 3 valid -> req 3 granted first (ptr=3), then req 1.
- Backpressure: out_valid=1, out_ready=0 for 4 cycles with all requests valid -> req_ready=0000, out_s/out_id stable, ptr stable. Raising out_ready -> the next grant and the pop occur on the same edge, and out_valid stays 1.
- Random: 1000 cycles, random valid/out_ready/digits -> every accepted pair yields exactly one result with the correct value and id, in acceptance order. Then assert rst_n=0 while FULL -> out_valid drops immediately without a clock edge, and ptr=0 after release.
